// File: rtl/sipo_frame_ctrl.sv
// Serial receive controller: start-bit detect, mid-bit sampling, LSB-first assembly, stop check, valid/ready holding register.
// Optional even-parity bit after the data bits is compiled in with `define SIPO_FRAME_CTRL_PARITY_EN.
module sipo_frame_ctrl #(
  parameter int CLKS_PER_BIT = 4,
  parameter int WORD_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_serial,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_word,
  output logic              o_valid,
  output logic              o_sample,
  output logic [3:0]        o_bit_idx,
  output logic              o_busy,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_parity_err
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(WORD_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              sample;
  logic              commit;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
  logic              perr_q, perr_d;
  logic              drop_q, drop_d;
`endif

  // Line is asynchronous; both flops idle high so reset never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync_q  <= 1'b1;
    end else begin
      sync1_q <= i_serial;
      sync_q  <= sync1_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
      perr_q    <= 1'b0;
      drop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
      perr_q    <= perr_d;
      drop_q    <= drop_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    sample    = 1'b0;
    commit    = 1'b0;
    ferr_d    = 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    perr_d    = 1'b0;
    drop_d    = drop_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!sync_q) begin
          state_d = ST_START;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
          drop_d  = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          if (!sync_q) begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          sample = 1'b1;
          cnt_d  = '0;
          for (int i = 0; i < WORD_W; i++) begin
            if (bit_idx_q == 4'(i)) shreg_d[i] = sync_q;
          end
          if (bit_idx_q == IDX_LAST) begin
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          if ((^shreg_q) != sync_q) begin
            perr_d = 1'b1;
            drop_d = 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sync_q) begin
            state_d = ST_IDLE;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            commit  = !drop_q;
`else
            commit  = 1'b1;
`endif
          end else begin
            state_d = ST_BREAK;
            ferr_d  = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (sync_q) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Disable abandons the frame in flight but leaves the holding register alone.
    if (!i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sample  = 1'b0;
      commit  = 1'b0;
      ferr_d  = 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
      perr_d  = 1'b0;
`endif
    end

    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && i_ready) valid_d = 1'b0;
    if (commit) begin
      if (!valid_q || i_ready) begin
        word_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d   = 1'b1;
      end
    end
  end

  assign o_word      = word_q;
  assign o_valid     = valid_q;
  assign o_sample    = sample;
  assign o_bit_idx   = bit_idx_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl at CLKS_PER_BIT=4, WORD_W=8; parity cases build with SIPO_FRAME_CTRL_PARITY_EN.
module tb_sipo_frame_ctrl;

  localparam int CPB = 4;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Start bit driven in cycle s: sync low at s+2, first sample s+2+HALF+CPB, valid one cycle after commit.
  localparam int LAT_SAMPLE = 2 + CPB / 2 + CPB;
  localparam int LAT_VALID  = 2 + CPB / 2 + (8 + 1 + PB) * CPB + 1;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_en = 1'b1;
  logic       i_serial = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] o_word;
  logic       o_valid, o_sample, o_busy, o_frame_err, o_overrun, o_parity_err;
  logic [3:0] o_bit_idx;

  sipo_frame_ctrl #(.CLKS_PER_BIT(CPB), .WORD_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_serial(i_serial), .i_ready(i_ready),
    .o_word(o_word), .o_valid(o_valid), .o_sample(o_sample), .o_bit_idx(o_bit_idx),
    .o_busy(o_busy), .o_frame_err(o_frame_err), .o_overrun(o_overrun),
    .o_parity_err(o_parity_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;
  int start_cyc = 0;
  int sample_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, busy_cnt = 0, valid_cnt = 0;
  int valid_rise_cyc = 0, ovr_cyc = 0;
  int idx_log[64];
  int samp_cyc[64];
  logic prev_valid = 1'b0;

  always @(negedge i_clk) begin
    if (o_sample) begin
      idx_log[sample_cnt % 64]  = int'(o_bit_idx);
      samp_cyc[sample_cnt % 64] = cyc;
      sample_cnt++;
    end
    if (o_valid && !prev_valid) valid_rise_cyc = cyc;
    if (o_overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (o_frame_err)  ferr_cnt++;
    if (o_parity_err) perr_cnt++;
    if (o_busy)       busy_cnt++;
    if (o_valid)      valid_cnt++;
    prev_valid = o_valid;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    i_serial = b;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(data[k]);
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    drive_bit(^data);
`endif
    drive_bit(stop);
  endtask

`ifdef SIPO_FRAME_CTRL_PARITY_EN
  task automatic send_frame_par(input logic [7:0] data, input logic par);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(data[k]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask
`endif

  initial begin
    int b_smp, b_ferr, b_ovr, b_perr, b_busy, b_val, s2;

    // Reset state
    idle(3);
    check("rst_word",  int'(o_word), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy",  int'(o_busy), 0);
    check("rst_flags", int'({o_sample, o_frame_err, o_overrun, o_parity_err}), 0);
    i_rst = 1'b0;
    idle(4);
    check("idle_busy", int'(o_busy), 0);

    // Frame 0xA5, consumer ready
    b_smp = sample_cnt; b_val = valid_cnt; b_ferr = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    idle(8);
    check("a5_nsamp", sample_cnt - b_smp, 8);
    for (int k = 0; k < 8; k++) check("a5_idx", idx_log[(b_smp + k) % 64], k);
    check("a5_samp_lat", samp_cyc[b_smp % 64] - start_cyc, LAT_SAMPLE);
    check("a5_bit7_lat", samp_cyc[(b_smp + 7) % 64] - start_cyc, LAT_SAMPLE + 7 * CPB);
    check("a5_valid_lat", valid_rise_cyc - start_cyc, LAT_VALID);
    check("a5_word", int'(o_word), 'hA5);
    check("a5_valid_cycles", valid_cnt - b_val, 1);
    check("a5_ferr", ferr_cnt - b_ferr, 0);

    // One-cycle low glitch
    b_smp = sample_cnt; b_val = valid_cnt; b_ferr = ferr_cnt; b_busy = busy_cnt;
    i_serial = 1'b0;
    idle(1);
    i_serial = 1'b1;
    idle(8);
    check("gl_busy_cycles", busy_cnt - b_busy, 2);
    check("gl_nsamp", sample_cnt - b_smp, 0);
    check("gl_valid", valid_cnt - b_val, 0);
    check("gl_ferr", ferr_cnt - b_ferr, 0);

    // Bad stop bit, line held low, then recovery
    b_val = valid_cnt; b_ferr = ferr_cnt;
    send_frame(8'h81, 1'b0);
    idle(20);
    check("br_ferr", ferr_cnt - b_ferr, 1);
    check("br_valid", valid_cnt - b_val, 0);
    check("br_busy", int'(o_busy), 1);
    check("br_word", int'(o_word), 'hA5);
    i_serial = 1'b1;
    idle(6);
    check("br_exit_busy", int'(o_busy), 0);
    send_frame(8'h7E, 1'b1);
    idle(8);
    check("br_next_word", int'(o_word), 'h7E);
    check("br_next_lat", valid_rise_cyc - start_cyc, LAT_VALID);
    check("br_ferr_total", ferr_cnt - b_ferr, 1);

    // Overrun: back-to-back frames with consumer stalled
    i_ready = 1'b0;
    b_ovr = ovr_cnt;
    send_frame(8'h11, 1'b1);
    s2 = cyc;
    send_frame(8'h22, 1'b1);
    idle(8);
    check("ov_word", int'(o_word), 'h11);
    check("ov_valid", int'(o_valid), 1);
    check("ov_count", ovr_cnt - b_ovr, 1);
    check("ov_lat", ovr_cyc - s2, LAT_VALID);
    i_ready = 1'b1;
    idle(1);
    check("ov_drain", int'(o_valid), 0);
    check("ov_hold_word", int'(o_word), 'h11);

    // Reset in the middle of data bit 3
    i_serial = 1'b0;
    idle(CPB);
    for (int k = 0; k < 3; k++) drive_bit(k[0]);
    i_serial = 1'b1;
    idle(2);
    check("mr_pre_busy", int'(o_busy), 1);
    check("mr_pre_idx", int'(o_bit_idx), 3);
    i_rst = 1'b1;
    #1;
    check("mr_busy", int'(o_busy), 0);
    check("mr_word", int'(o_word), 0);
    check("mr_idx", int'(o_bit_idx), 0);
    idle(2);
    i_rst = 1'b0;
    idle(4);
    send_frame(8'h3C, 1'b1);
    idle(8);
    check("mr_next_word", int'(o_word), 'h3C);
    check("mr_next_lat", valid_rise_cyc - start_cyc, LAT_VALID);

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    // Parity: wrong bit discards, correct bit commits
    b_perr = perr_cnt; b_val = valid_cnt;
    send_frame_par(8'h07, 1'b0);
    idle(8);
    check("pe_err", perr_cnt - b_perr, 1);
    check("pe_valid", valid_cnt - b_val, 0);
    check("pe_word", int'(o_word), 'h3C);
    b_perr = perr_cnt;
    send_frame_par(8'h07, 1'b1);
    idle(8);
    check("pe_ok_err", perr_cnt - b_perr, 0);
    check("pe_ok_word", int'(o_word), 'h07);
`else
    b_perr = 0;
    check("perr_never", perr_cnt - b_perr, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Receive-side controller for the 8-bit serial-to-parallel collector. It detects a start bit on the serial line and paces bit sampling with a clock-divider counter. It sequences the shift of each data bit LSB-first into the word, then validates the stop bit. The assembled word goes to a holding register behind a valid/ready handshake toward the consuming logic.

## Interface
- `CLKS_PER_BIT`, 4, i_clk cycles per serial bit; legal range 4..255.
- `WORD_W`, 8, data bits per frame; legal range 1..16.
- `i_clk`  in  1  sole clock; all flops rise-edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_en`  in  1  receiver enable; low forces IDLE.
- `i_serial`  in  1  serial line, idle high, asynchronous to i_clk.
- `i_ready`  in  1  consumer accepts o_word when o_valid is high.
- `o_word`  out  WORD_W  last committed word.
- `o_valid`  out  1  o_word holds an unconsumed word.
- `o_sample`  out  1  one-cycle strobe on each data-bit sample.
- `o_bit_idx`  out  4  index of the bit being sampled, valid with o_sample.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `o_overrun`  out  1  one-cycle pulse when a word is dropped.
- `o_parity_err`  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

## Operation
- `i_serial` passes through a 2-flop synchronizer (`sync`); both flops reset to 1.
- Define `HALF = CLKS_PER_BIT/2`, using integer division.
- Bit counter `cnt` is a ceil(log2(CLKS_PER_BIT))-bit counter.
- **IDLE**
  - `sync==0 && i_en` -> START, `cnt=0`.
- **START**
  - At `cnt==HALF-1`, sample the line.
  - Line low -> DATA, `cnt=0`, `bit_idx=0`.
  - Line high -> IDLE. This is a glitch: no error flag is raised.
- **DATA**
  - At `cnt==CLKS_PER_BIT-1`:
    - shift the line into `shreg[bit_idx]`;
    - pulse `o_sample` with the current `o_bit_idx`;
    - `cnt=0`.
  - After bit `WORD_W-1`, go to STOP, or to PARITY when parity is compiled in.
- **STOP**
  - At `cnt==CLKS_PER_BIT-1`, sample the line.
  - Line high -> commit and go to IDLE.
  - Line low -> pulse `o_frame_err`, discard the word, go to BREAK.
- **BREAK**
  - Stay until `sync==1`, then go to IDLE.
  - This prevents a held-low line from being taken as a new start bit.
- **Commit**
  - Case `!o_valid`, or `o_valid && i_ready` in the same cycle:
    - `o_word<=shreg`, `o_valid<=1`.
  - Case `o_valid && !i_ready`:
    - the word is dropped and `o_overrun` pulses;
    - `o_word` is unchanged.
- **Handshake**
  - `o_valid && i_ready` with no commit -> `o_valid<=0` next cycle.
  - `o_word` holds its value.
- **`i_en` low**
  - Any state goes to IDLE next cycle, and the partial word is discarded.
  - `o_word` and `o_valid` are untouched; the handshake still operates.
- **Reset values**
  - All outputs are 0 and the state is IDLE.
  - `shreg`, `cnt` and `bit_idx` are 0.

## Timing
- Synchronizer latency is 2 cycles from an `i_serial` change to `sync`.
- Let cycle d be the first IDLE cycle with `sync==0`.
- `o_sample` for bit k is high in cycle `d+HALF+(k+1)*CLKS_PER_BIT`.
- Commit occurs in cycle `d+HALF+(WORD_W+1)*CLKS_PER_BIT` (+CLKS_PER_BIT with parity).
- `o_valid` rises the following cycle.
- `o_frame_err` and `o_overrun` are registered: high in the cycle after the STOP sample, for exactly one cycle.
- Back-to-back frames: IDLE can detect a new start bit one cycle after commit, with no dead time beyond that.
- The design must sustain continuous frames at full line rate provided the consumer holds `i_ready=1`.

## Configuration
- Macro `SIPO_FRAME_CTRL_PARITY_EN`.
- **Defined:**
  - a PARITY state follows DATA and samples one even-parity bit at `cnt==CLKS_PER_BIT-1`;
  - on mismatch, `o_parity_err` pulses, the word is discarded, and the block continues to STOP (stop-bit check still performed);
  - the frame is `1+WORD_W+1+1` bits.
- **Undefined:**
  - there is no PARITY state;
  - `o_parity_err` is constant 0;
  - the frame is `1+WORD_W+1` bits.

## Test plan
- Reset mid-frame (assert `i_rst` during DATA bit 3) -> all outputs 0 immediately, IDLE; the next clean frame of 0x3C is received correctly.
- `CLKS_PER_BIT=4`, frame 0xA5 with stop=1, `i_ready=1` -> exactly 8 `o_sample` pulses with `o_bit_idx` 0..7; `o_word=0xA5`; `o_valid` high 1 cycle after commit, cleared next cycle.
- Low glitch of 1 cycle on `i_serial` -> `o_busy` pulses briefly; no `o_sample`, `o_valid` or error output.
- Frame 0x81 with stop bit=0 and the line then held low for 20 cycles -> `o_frame_err` pulses once, `o_valid` stays 0, the block stays in BREAK; a following 0x7E frame after the line returns high is received.
- Two frames 0x11 then 0x22 with `i_ready=0` -> `o_word=0x11`, `o_overrun` pulses once at the second commit; `i_ready=1` then clears `o_valid`.
- With `SIPO_FRAME_CTRL_PARITY_EN`, frame 0x07 with parity bit 0 (wrong) -> `o_parity_err` pulses, no commit; the same frame with parity 1 -> `o_word=0x07`.
